// File: rtl/sfr_pkg.sv
// sfr_pkg: op encodings, FSM states and default SFR addresses for sfr_access_ctrl.
// ST_WR exists only when SFR_RMW_EN is defined.
package sfr_pkg;
    localparam logic [1:0] OP_BRD   = 2'b00;
    localparam logic [1:0] OP_BWR   = 2'b01;
    localparam logic [1:0] OP_BITRD = 2'b10;
    localparam logic [1:0] OP_BITWR = 2'b11;

    localparam logic [7:0] SFR_P0  = 8'h80;
    localparam logic [7:0] SFR_PSW = 8'hD0;
    localparam logic [7:0] SFR_ACC = 8'hE0;
    localparam logic [7:0] SFR_B   = 8'hF0;
    localparam logic [31:0] SFR_MAP_DEFAULT = {SFR_B, SFR_ACC, SFR_PSW, SFR_P0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
`ifdef SFR_RMW_EN
        ST_WR,
`endif
        ST_RESP
    } state_t;
endpackage

// File: rtl/sfr_addr_decode.sv
// sfr_addr_decode: maps an 8051 direct/bit address to a one-hot SFR slot and bit position.
// Bit addresses below 0x80 never match, so they report unmapped.
module sfr_addr_decode
    import sfr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NUM_SFR = 4,
    parameter logic [NUM_SFR*8-1:0] SFR_MAP = SFR_MAP_DEFAULT
) (
    input  logic [7:0]         i_addr,
    input  logic [1:0]         i_op,
    output logic [NUM_SFR-1:0] o_slot,
    output logic [WIDTH-1:0]   o_pos,
    output logic               o_unmapped
);
    logic       w_bit;
    logic [7:0] w_key;

    always_comb begin
        w_bit = (i_op == OP_BITRD) || (i_op == OP_BITWR);
        w_key = w_bit ? {i_addr[7:3], 3'b000} : i_addr;
        o_slot = '0;
        for (int i = 0; i < NUM_SFR; i++)
            o_slot[i] = (SFR_MAP[8*i +: 8] == w_key) && (!w_bit || i_addr[7]);
        o_pos = w_bit ? WIDTH'(1) << i_addr[2:0] : '0;
        o_unmapped = ~|o_slot;
    end
endmodule

// File: rtl/sfr_access_ctrl.sv
// sfr_access_ctrl: sequences one byte/bit SFR access per request and returns a response.
// Define SFR_RMW_EN to turn a bit write with req_tgl into an atomic read-toggle-write.
module sfr_access_ctrl
    import sfr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NUM_SFR = 4,
    parameter logic [NUM_SFR*8-1:0] SFR_MAP = SFR_MAP_DEFAULT
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [1:0]               i_req_op,
    input  logic [7:0]               i_req_addr,
    input  logic [WIDTH-1:0]         i_req_wdata,
    input  logic                     i_req_wbit,
    input  logic                     i_req_tgl,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [WIDTH-1:0]         o_rsp_data,
    output logic                     o_rsp_err,
    output logic [NUM_SFR-1:0]       o_sfr_en,
    output logic [NUM_SFR-1:0]       o_sfr_oe,
    output logic                     o_sfr_Bb,
    output logic [WIDTH-1:0]         o_sfr_position,
    output logic [WIDTH-1:0]         o_sfr_din,
    output logic                     o_sfr_bin,
    input  logic [NUM_SFR*WIDTH-1:0] i_sfr_dout,
    input  logic [NUM_SFR-1:0]       i_sfr_bout
);
    state_t             r_state, w_next;
    logic [1:0]         r_op;
    logic [NUM_SFR-1:0] r_slot, w_slot;
    logic [WIDTH-1:0]   r_pos, w_pos, r_wdata, r_rsp_data, w_rd_byte;
    logic               r_wbit, r_rsp_err, w_unmapped, w_rd_bit, w_rmw, w_accept;

    sfr_addr_decode #(
        .WIDTH(WIDTH),
        .NUM_SFR(NUM_SFR),
        .SFR_MAP(SFR_MAP)
    ) u_dec (
        .i_addr(i_req_addr),
        .i_op(i_req_op),
        .o_slot(w_slot),
        .o_pos(w_pos),
        .o_unmapped(w_unmapped)
    );

    assign w_accept = (r_state == ST_IDLE) && i_req_valid;

`ifdef SFR_RMW_EN
    logic r_tgl;
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            r_tgl <= 1'b0;
        else if (w_accept)
            r_tgl <= i_req_tgl;
    end
    assign w_rmw = r_tgl && (r_op == OP_BITWR);
    // The WR phase writes back the inverse of the bit captured during WAIT.
    assign o_sfr_bin = (r_state == ST_WR) ? ~r_rsp_data[0] : r_wbit;
`else
    logic w_unused;
    assign w_unused = i_req_tgl;
    assign w_rmw = 1'b0;
    assign o_sfr_bin = r_wbit;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        o_sfr_en = '0;
        o_sfr_oe = '0;
        case (r_state)
            ST_IDLE: if (i_req_valid) w_next = w_unmapped ? ST_RESP : ST_ISSUE;
            ST_ISSUE: begin
                if (r_op[0] && !w_rmw) begin
                    o_sfr_en = r_slot;
                    w_next = ST_RESP;
                end else begin
                    o_sfr_oe = r_slot;
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                o_sfr_oe = r_slot;
`ifdef SFR_RMW_EN
                w_next = w_rmw ? ST_WR : ST_RESP;
`else
                w_next = ST_RESP;
`endif
            end
`ifdef SFR_RMW_EN
            ST_WR: begin
                o_sfr_en = r_slot;
                w_next = ST_RESP;
            end
`endif
            ST_RESP: if (i_rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_byte = '0;
        for (int i = 0; i < NUM_SFR; i++)
            if (r_slot[i]) w_rd_byte = w_rd_byte | i_sfr_dout[i*WIDTH +: WIDTH];
        w_rd_bit = |(r_slot & i_sfr_bout);
    end

    // Unmapped requests skip ISSUE, so their slot stays zero and no strobe fires.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_op       <= '0;
            r_slot     <= '0;
            r_pos      <= '0;
            r_wdata    <= '0;
            r_wbit     <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else if (w_accept) begin
            r_op       <= i_req_op;
            r_slot     <= w_slot;
            r_pos      <= w_pos;
            r_wdata    <= i_req_wdata;
            r_wbit     <= i_req_wbit;
            r_rsp_err  <= w_unmapped;
            r_rsp_data <= w_unmapped ? '1 : '0;
        end else if (r_state == ST_WAIT) begin
            r_rsp_data <= r_op[1] ? WIDTH'(w_rd_bit) : w_rd_byte;
        end
    end

    assign o_req_ready    = r_state == ST_IDLE;
    assign o_rsp_valid    = r_state == ST_RESP;
    assign o_rsp_data     = r_rsp_data;
    assign o_rsp_err      = r_rsp_err;
    assign o_sfr_Bb       = ~r_op[1];
    assign o_sfr_position = r_pos;
    assign o_sfr_din      = r_wdata;
endmodule

// File: tb/tb_sfr_access_ctrl.sv
// tb_sfr_access_ctrl: scoreboard bench for sfr_access_ctrl with a behavioural SFR array.
// Exercises the SFR_RMW_EN toggle path when that macro is defined.
module tb_sfr_access_ctrl;
    import sfr_pkg::*;
    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_ready, req_wbit = 1'b0, req_tgl = 1'b0;
    logic [1:0] req_op = '0;
    logic [7:0] req_addr = '0;
    logic [W-1:0] req_wdata = '0, rsp_data, pos, din;
    logic rsp_valid, rsp_ready = 1'b0, rsp_err, bb, bin;
    logic [N-1:0] en, oe, bout_r = '0;
    logic [N*W-1:0] dout;
    logic [W-1:0] sfr_reg [N] = '{default: '0};

    int checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
    int en_cyc = 0, oe_cyc = 0;
    logic [N-1:0] en_seen = '0;
    logic bb_seen = 1'b0, multi = 1'b0, hold_ready = 1'b0;
    logic [W-1:0] pos_seen = '0;
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sfr_access_ctrl dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wbit(req_wbit),
        .i_req_tgl(req_tgl), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_sfr_en(en), .o_sfr_oe(oe),
        .o_sfr_Bb(bb), .o_sfr_position(pos), .o_sfr_din(din), .o_sfr_bin(bin),
        .i_sfr_dout(dout), .i_sfr_bout(bout_r)
    );

    assign dout = {sfr_reg[3], sfr_reg[2], sfr_reg[1], sfr_reg[0]};

    // Slot model: registered byte and bit outputs, updated by en/oe strobes.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (en[i]) sfr_reg[i] <= bb ? din : (sfr_reg[i] & ~pos) | (bin ? pos : '0);
            if (oe[i]) bout_r[i] <= |(sfr_reg[i] & pos);
        end
    end

    always @(negedge clk) begin
        if (en != 0) begin
            en_cyc++;
            en_seen = en;
            bb_seen = bb;
            pos_seen = pos;
        end
        if (oe != 0) oe_cyc++;
        if ($countones(en | oe) > 1) multi = 1'b1;
    end

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [W-1:0] wd,
                        input logic wb, input logic tg, input logic [8:0] e);
        int n = 0;
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; req_wbit = wb; req_tgl = tg;
        exp_q.push_back(e);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL accept got=ready0 exp=ready1");
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 acc_cyc = cyc;
            req_valid = 1'b0;
        end
    endtask

    task automatic get_rsp(output logic [8:0] obs, output int lat);
        obs = 'x;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                obs = {rsp_err, rsp_data};
                lat = cyc - acc_cyc;
                rsp_ready = 1'b1;
                @(negedge clk);
                rsp_ready = hold_ready;
                break;
            end
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [7:0] a, input logic [W-1:0] wd,
                       input logic wb, input logic tg, input logic [8:0] e,
                       output logic [8:0] obs, output logic [8:0] expv, output int lat);
        en_cyc = 0; oe_cyc = 0; en_seen = '0;
        send(op, a, wd, wb, tg, e);
        get_rsp(obs, lat);
        expv = exp_q.size() > 0 ? exp_q.pop_front() : 9'h0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp got=%b%b exp=00", rsp_valid, rsp_err); end
        checks++; if (rsp_data !== '0) begin failures++; $display("FAIL rst_data got=%h exp=00", rsp_data); end
        checks++; if ((en | oe) !== '0) begin failures++; $display("FAIL rst_strobe got=%b/%b exp=0/0", en, oe); end
    endtask

    task automatic test_byte;
        logic [8:0] o, e; int l;
        run(OP_BWR, 8'hE0, 8'h5A, 1'b0, 1'b0, 9'h000, o, e, l);
        checks++; if (o !== e) begin failures++; $display("FAIL bw_rsp got=%h exp=%h", o, e); end
        checks++; if (l !== 1) begin failures++; $display("FAIL bw_lat got=%0d exp=1", l); end
        checks++; if (en_cyc !== 1 || en_seen !== 4'b0100 || bb_seen !== 1'b1) begin failures++; $display("FAIL bw_strobe got=%0d/%b/%b exp=1/0100/1", en_cyc, en_seen, bb_seen); end
        checks++; if (sfr_reg[2] !== 8'h5A) begin failures++; $display("FAIL bw_acc got=%h exp=5a", sfr_reg[2]); end
        run(OP_BRD, 8'hE0, 8'h00, 1'b0, 1'b0, 9'h05A, o, e, l);
        checks++; if (o !== e) begin failures++; $display("FAIL br_rsp got=%h exp=%h", o, e); end
        checks++; if (l !== 2) begin failures++; $display("FAIL br_lat got=%0d exp=2", l); end
        checks++; if (oe_cyc !== 2 || en_cyc !== 0) begin failures++; $display("FAIL br_strobe got=%0d/%0d exp=2/0", oe_cyc, en_cyc); end
    endtask

    task automatic test_bit;
        logic [8:0] o, e; int l;
        run(OP_BITWR, 8'hD3, 8'h00, 1'b1, 1'b0, 9'h000, o, e, l);
        checks++; if (o !== e || l !== 1) begin failures++; $display("FAIL bitw_rsp got=%h/%0d exp=%h/1", o, l, e); end
        checks++; if (en_seen !== 4'b0010 || bb_seen !== 1'b0 || pos_seen !== 8'h08) begin failures++; $display("FAIL bitw_strobe got=%b/%b/%h exp=0010/0/08", en_seen, bb_seen, pos_seen); end
        checks++; if (sfr_reg[1] !== 8'h08) begin failures++; $display("FAIL bitw_psw got=%h exp=08", sfr_reg[1]); end
        run(OP_BITRD, 8'hD3, 8'h00, 1'b0, 1'b0, 9'h001, o, e, l);
        checks++; if (o !== e || l !== 2) begin failures++; $display("FAIL bitr_set got=%h/%0d exp=%h/2", o, l, e); end
        run(OP_BITRD, 8'hD2, 8'h00, 1'b0, 1'b0, 9'h000, o, e, l);
        checks++; if (o !== e) begin failures++; $display("FAIL bitr_clr got=%h exp=%h", o, e); end
    endtask

    task automatic test_unmapped;
        logic [8:0] o, e; int l;
        logic [7:0] addrs [4] = '{8'h90, 8'h45, 8'h7F, 8'h81};
        logic [1:0] ops [4] = '{OP_BRD, OP_BITRD, OP_BITWR, OP_BWR};
        for (int i = 0; i < 4; i++) begin
            run(ops[i], addrs[i], 8'h11, 1'b1, 1'b0, 9'h1FF, o, e, l);
            checks++; if (o !== e || en_cyc !== 0 || oe_cyc !== 0) begin failures++; $display("FAIL unmapped_%h got=%h/%0d/%0d exp=%h/0/0", addrs[i], o, en_cyc, oe_cyc, e); end
        end
        run(OP_BITRD, 8'h80, 8'h00, 1'b0, 1'b0, 9'h000, o, e, l);
        checks++; if (o !== e || oe_cyc !== 2) begin failures++; $display("FAIL bit80_mapped got=%h/%0d exp=%h/2", o, oe_cyc, e); end
        checks++; if (sfr_reg[0] !== 8'h00 || sfr_reg[1] !== 8'h08) begin failures++; $display("FAIL unmapped_side got=%h/%h exp=00/08", sfr_reg[0], sfr_reg[1]); end
    endtask

    task automatic test_backpressure;
        logic [8:0] o, e; int l;
        send(OP_BRD, 8'hE0, 8'h00, 1'b0, 1'b0, 9'h05A);
        for (int n = 0; n < 10 && !rsp_valid; n++) @(negedge clk);
        req_valid = 1'b1; req_op = OP_BWR; req_addr = 8'h80; req_wdata = 8'h33;
        exp_q.push_back(9'h000);
        en_cyc = 0;
        repeat (5) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || {rsp_err, rsp_data} !== 9'h05A || req_ready !== 1'b0) begin failures++; $display("FAIL bp_hold got=%b/%h/%b exp=1/05a/0", rsp_valid, {rsp_err, rsp_data}, req_ready); end
        end
        checks++; if (en_cyc !== 0 || sfr_reg[0] !== 8'h00) begin failures++; $display("FAIL bp_no_accept got=%0d/%h exp=0/00", en_cyc, sfr_reg[0]); end
        e = exp_q.pop_front();
        checks++; if ({rsp_err, rsp_data} !== e) begin failures++; $display("FAIL bp_rsp got=%h exp=%h", {rsp_err, rsp_data}, e); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 acc_cyc = cyc;
        req_valid = 1'b0;
        get_rsp(o, l);
        e = exp_q.pop_front();
        checks++; if (o !== e || l !== 1 || sfr_reg[0] !== 8'h33) begin failures++; $display("FAIL bp_second got=%h/%0d/%h exp=%h/1/33", o, l, sfr_reg[0], e); end
    endtask

    task automatic test_back_to_back;
        logic [8:0] o, e; int l, prev;
        logic [1:0] ops [4] = '{OP_BWR, OP_BRD, OP_BITWR, OP_BRD};
        logic [7:0] dat [4] = '{8'hA5, 8'h00, 8'h00, 8'h00};
        logic [8:0] exps [4] = '{9'h000, 9'h0A5, 9'h000, 9'h0A4};
        int gap [4] = '{0, 3, 4, 3};
        hold_ready = 1'b1;
        rsp_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            run(ops[i], 8'hF0, dat[i], 1'b0, 1'b0, exps[i], o, e, l);
            checks++; if (o !== e) begin failures++; $display("FAIL b2b_rsp%0d got=%h exp=%h", i, o, e); end
            if (i > 0) begin
                checks++; if (acc_cyc - prev !== gap[i]) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, acc_cyc - prev, gap[i]); end
            end
            prev = acc_cyc;
        end
        hold_ready = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_toggle;
        logic [8:0] o, e; int l;
`ifdef SFR_RMW_EN
        run(OP_BWR, 8'hD0, 8'h00, 1'b0, 1'b0, 9'h000, o, e, l);
        run(OP_BITWR, 8'hD7, 8'h00, 1'b0, 1'b1, 9'h000, o, e, l);
        checks++; if (o !== e || l !== 3 || sfr_reg[1] !== 8'h80) begin failures++; $display("FAIL tgl1 got=%h/%0d/%h exp=%h/3/80", o, l, sfr_reg[1], e); end
        run(OP_BITWR, 8'hD7, 8'h00, 1'b0, 1'b1, 9'h001, o, e, l);
        checks++; if (o !== e || l !== 3 || sfr_reg[1] !== 8'h00) begin failures++; $display("FAIL tgl2 got=%h/%0d/%h exp=%h/3/00", o, l, sfr_reg[1], e); end
`else
        run(OP_BITWR, 8'hD7, 8'h00, 1'b1, 1'b1, 9'h000, o, e, l);
        checks++; if (o !== e || l !== 1 || sfr_reg[1] !== 8'h88) begin failures++; $display("FAIL tgl_ign1 got=%h/%0d/%h exp=%h/1/88", o, l, sfr_reg[1], e); end
        run(OP_BITWR, 8'hD7, 8'h00, 1'b1, 1'b1, 9'h000, o, e, l);
        checks++; if (o !== e || sfr_reg[1] !== 8'h88) begin failures++; $display("FAIL tgl_ign2 got=%h/%h exp=%h/88", o, sfr_reg[1], e); end
`endif
    endtask

    task automatic test_reset_wait;
        send(OP_BRD, 8'hD0, 8'h00, 1'b0, 1'b0, 9'h000);
        @(posedge clk);
        #1;
        checks++; if (oe !== 4'b0010) begin failures++; $display("FAIL wait_oe got=%b exp=0010", oe); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (oe !== '0 || en !== '0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rstwait_drop got=%b/%b/%b exp=0/0/0", oe, en, rsp_valid); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        en_cyc = 0; oe_cyc = 0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || en_cyc !== 0 || oe_cyc !== 0) begin failures++; $display("FAIL rstwait_idle got=%b/%b/%0d/%0d exp=1/0/0/0", req_ready, rsp_valid, en_cyc, oe_cyc); end
    endtask

    initial begin
        test_reset;
        test_byte;
        test_bit;
        test_unmapped;
        test_backpressure;
        test_back_to_back;
        test_toggle;
        test_reset_wait;
        checks++; if (multi !== 1'b0) begin failures++; $display("FAIL onehot got=%b exp=0", multi); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sfr_access_ctrl.md
Name: sfr_access_ctrl

Overview:
- Sequencer between the CPU execute stage and the array of special-function registers (SFRs).
- Accepts one byte or bit access per request over a valid/ready handshake.
- Decodes the 8051 direct or bit address into a one-hot SFR slot and a one-hot bit position.
- Drives each slot's en/oe/Bb/position/din/bin strobes, captures the slot's registered dout/bout one cycle later, and returns a response over a valid/ready handshake.

Parameters:
- WIDTH, 8, SFR data width. position is one-hot over WIDTH.
- NUM_SFR, 4, number of SFR slots served.
- SFR_MAP, {8'hF0,8'hE0,8'hD0,8'h80}, packed NUM_SFR*8 byte addresses. Slot i = bits [8i+7:8i].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE.
- req_op  input  2  00 byte read, 01 byte write, 10 bit read, 11 bit write.
- req_addr  input  8  direct byte address (byte ops) or bit address (bit ops).
- req_wdata  input  WIDTH  byte write data.
- req_wbit  input  1  bit write data.
- req_tgl  input  1  toggle modifier; used only with SFR_RMW_EN.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed.
- rsp_data  output  WIDTH  read data. For bit reads, the bit is in bit 0 and the upper bits are zero.
- rsp_err  output  1  address unmapped.
- sfr_en  output  NUM_SFR  per-slot write enable.
- sfr_oe  output  NUM_SFR  per-slot output enable.
- sfr_Bb  output  1  1 = byte access, 0 = bit access.
- sfr_position  output  WIDTH  one-hot bit select.
- sfr_din  output  WIDTH  byte write data.
- sfr_bin  output  1  bit write data.
- sfr_dout  input  NUM_SFR*WIDTH  concatenated registered slot byte outputs.
- sfr_bout  input  NUM_SFR  registered slot bit outputs.

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - sfr_en=0, sfr_oe=0, rsp_valid=0, rsp_err=0, rsp_data=0, latched request cleared.
  - A reset mid-access aborts the access. No strobe is asserted after reset falls.
- Address decode:
  - Byte ops: a slot matches when SFR_MAP[i] == req_addr.
  - Bit ops: require req_addr[7]=1. Slot matches when SFR_MAP[i] == {req_addr[7:3],3'b000}; position = 1 << req_addr[2:0].
  - Bit address < 0x80, or no match: unmapped.
- States:
  - IDLE: req_ready=1. On req_valid, latch op/addr/data/decode.
    - Mapped request goes to ISSUE.
    - Unmapped request goes to RESP with rsp_err=1, rsp_data=all-ones, and no strobes.
  - ISSUE (1 cycle): Bb = ~op[1]; position is latched. Byte ops drive position 0.
    - Writes: sfr_en[slot]=1; next state RESP.
    - Reads: sfr_oe[slot]=1; next state WAIT.
  - WAIT (1 cycle): sfr_oe[slot] stays 1 so that the registered slot output is stable. At exit, capture sfr_dout slice or sfr_bout[slot] into rsp_data; next state RESP.
  - RESP: rsp_valid=1. Response fields are held stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE.
- Outside the states listed above, all sfr_en/sfr_oe bits are 0. At most one bit of sfr_en|sfr_oe is ever set.
- Latency, counted from the acceptance edge:
  - Write: rsp_valid after 1 cycle.
  - Read: rsp_valid after 2 cycles.
  - Unmapped: rsp_valid after 1 cycle.
- Back-to-back throughput: no new request is accepted before the previous response handshakes, because req_ready=0 outside IDLE. Zero-bubble is not required.
- rsp_ready held high in RESP: return to IDLE next cycle. A new request may be accepted in that IDLE cycle.
- Writes return rsp_data=0, rsp_err=0.

Optional Feature:
- SFR_RMW_EN defined: bit write with req_tgl=1 performs an atomic toggle (CPL bit).
  - ISSUE (oe, bit) → WAIT (capture old bit) → WR (sfr_en, Bb=0, bin=~old) → RESP.
  - rsp_data[0] = old bit. Latency is 3 cycles.
- SFR_RMW_EN undefined: req_tgl is ignored and the op executes as coded. The WR state is absent.

Decomposition:
- Package sfr_pkg holds:
  - Op encodings (OP_BRD, OP_BWR, OP_BITRD, OP_BITWR).
  - FSM state enum.
  - Default SFR address constants (P0=8'h80, PSW=8'hD0, ACC=8'hE0, B=8'hF0).
- Sub-module sfr_addr_decode: combinational; takes addr and op, produces slot one-hot, position one-hot, and unmapped flag.

Test Plan:
- Byte write: op01 addr 0xE0 data 0x5A → sfr_en=4'b0100 for exactly 1 cycle, Bb=1; rsp 1 cycle later. A subsequent byte read of 0xE0 returns 0x5A, err=0, 2 cycles after acceptance.
- Bit write: op11 addr 0xD3 bin=1 → sfr_en=4'b0010, Bb=0, position=8'h08. A bit read of 0xD3 returns rsp_data=0x01.
- Unmapped: byte read 0x90 and bit read 0x45 → no strobes; rsp_err=1, rsp_data=0xFF.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp fields stable, req_ready=0, a second req_valid is not accepted.
- Reset during WAIT: assert reset low → sfr_oe drops immediately; rsp_valid=0; after release, req_ready=1.
- With SFR_RMW_EN: PSW=0x00, toggle 0xD7 → rsp_data=0x00, PSW becomes 0x80. A repeat toggle returns 0x01, PSW becomes 0x00.
